// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encodings and parameter defaults for the RAM arbiter.
package ram_arb_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 1;
   localparam int DEF_RD_LAT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection between two requesters.
// Build option ARB_ROUND_ROBIN_EN: on a tie the requester other than LAST wins.
// Without it requester 0 always wins ties and LAST is ignored.
module ram_arb_pick (
   input  logic REQ0,
   input  logic REQ1,
   input  logic LAST,
   output logic GNT
);

`ifdef ARB_ROUND_ROBIN_EN
   // Requester 1 wins when alone, or on a tie when requester 0 was served last.
   assign GNT = REQ1 & (~REQ0 | ~LAST);
`else
   logic unused_last;
   assign unused_last = LAST;
   // Requester 1 wins only when requester 0 is idle.
   assign GNT = REQ1 & ~REQ0;
`endif

endmodule

// File: rtl/ram_arb_ctrl.sv
// ram_arb_ctrl: two-requester arbiter and sequencer for the synchronous RAM.
// One command cycle (ISSUE), RD_LAT-1 WAIT cycles for reads, then a one-cycle ACK (RESP).
// Build option ARB_ROUND_ROBIN_EN: round-robin tie breaking with a LAST register;
// the default build uses fixed priority (requester 0) and has no LAST register.
module ram_arb_ctrl
   import ram_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = DEF_RD_LAT
)(
   input  logic              CLK,
   input  logic              CLR,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic              R_W0,
   input  logic              R_W1,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] DIN0,
   input  logic [DATA_W-1:0] DIN1,
   output logic              ACK0,
   output logic              ACK1,
   output logic [DATA_W-1:0] DOUT,
   output logic              BUSY,
   output logic              RAM_EN,
   output logic              RAM_R_W,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_DIN,
   input  logic [DATA_W-1:0] RAM_DOUT
);

   // WAIT lasts RD_LAT-1 cycles; the counter is loaded with one less than that.
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

   state_t            state;
   logic [CNT_W-1:0]  wcnt;
   logic              win;
   logic              rw_q;
   logic              gnt;
   logic              last;
   logic              sel_rw;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_din;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q;
   assign last = last_q;

   // Remember the most recent winner so ties alternate.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR)
         last_q <= 1'b1;
      else if (state == IDLE && (REQ0 || REQ1))
         last_q <= gnt;
   end
`else
   assign last = 1'b1;
`endif

   ram_arb_pick u_pick (
      .REQ0 (REQ0),
      .REQ1 (REQ1),
      .LAST (last),
      .GNT  (gnt)
   );

   assign sel_rw   = gnt ? R_W1  : R_W0;
   assign sel_addr = gnt ? ADDR1 : ADDR0;
   assign sel_din  = gnt ? DIN1  : DIN0;

   // Transaction sequencer; every output is registered and follows the state it enters.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state    <= IDLE;
         wcnt     <= '0;
         win      <= 1'b0;
         rw_q     <= 1'b0;
         ACK0     <= 1'b0;
         ACK1     <= 1'b0;
         DOUT     <= '0;
         BUSY     <= 1'b0;
         RAM_EN   <= 1'b0;
         RAM_R_W  <= 1'b0;
         RAM_ADDR <= '0;
         RAM_DIN  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (REQ0 || REQ1) begin
                  state    <= ISSUE;
                  win      <= gnt;
                  rw_q     <= sel_rw;
                  BUSY     <= 1'b1;
                  RAM_EN   <= 1'b1;
                  RAM_R_W  <= sel_rw;
                  RAM_ADDR <= sel_addr;
                  RAM_DIN  <= sel_din;
               end
            end
            ISSUE: begin
               RAM_EN  <= 1'b0;
               RAM_R_W <= 1'b0;
               if (rw_q || RD_LAT == 1) begin
                  state    <= RESP;
                  ACK0     <= ~win;
                  ACK1     <= win;
                  RAM_ADDR <= '0;
                  RAM_DIN  <= '0;
                  if (!rw_q)
                     DOUT <= RAM_DOUT;
               end else begin
                  state <= WAIT;
                  wcnt  <= WAIT_LOAD;
               end
            end
            WAIT: begin
               if (wcnt == '0) begin
                  state    <= RESP;
                  ACK0     <= ~win;
                  ACK1     <= win;
                  DOUT     <= RAM_DOUT;
                  RAM_ADDR <= '0;
                  RAM_DIN  <= '0;
               end else begin
                  wcnt <= wcnt - 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               ACK0  <= 1'b0;
               ACK1  <= 1'b0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// tb_ram_arb_ctrl: scoreboard bench for ram_arb_ctrl.
// Instance A uses RD_LAT=1, instance B uses RD_LAT=3; each has its own RAM model.
module tb_ram_arb_ctrl;

   logic CLK = 1'b0;
   logic CLR;
   always #5 CLK = ~CLK;

   logic [1:0] req_a, req_b;
   logic       r_w0, r_w1;
   logic [0:0] addr0, addr1;
   logic [7:0] din0, din1;

   logic       a_ack0, a_ack1, a_busy, a_en, a_rw;
   logic [0:0] a_addr;
   logic [7:0] a_dout, a_din, a_rdout;
   logic       b_ack0, b_ack1, b_busy, b_en, b_rw;
   logic [0:0] b_addr;
   logic [7:0] b_dout, b_din, b_rdout;

   ram_arb_ctrl #(.DATA_W(8), .ADDR_W(1), .RD_LAT(1)) u_a (
      .CLK(CLK), .CLR(CLR), .REQ0(req_a[0]), .REQ1(req_a[1]),
      .R_W0(r_w0), .R_W1(r_w1), .ADDR0(addr0), .ADDR1(addr1), .DIN0(din0), .DIN1(din1),
      .ACK0(a_ack0), .ACK1(a_ack1), .DOUT(a_dout), .BUSY(a_busy),
      .RAM_EN(a_en), .RAM_R_W(a_rw), .RAM_ADDR(a_addr), .RAM_DIN(a_din), .RAM_DOUT(a_rdout));

   ram_arb_ctrl #(.DATA_W(8), .ADDR_W(1), .RD_LAT(3)) u_b (
      .CLK(CLK), .CLR(CLR), .REQ0(req_b[0]), .REQ1(req_b[1]),
      .R_W0(r_w0), .R_W1(r_w1), .ADDR0(addr0), .ADDR1(addr1), .DIN0(din0), .DIN1(din1),
      .ACK0(b_ack0), .ACK1(b_ack1), .DOUT(b_dout), .BUSY(b_busy),
      .RAM_EN(b_en), .RAM_R_W(b_rw), .RAM_ADDR(b_addr), .RAM_DIN(b_din), .RAM_DOUT(b_rdout));

   // RAM models: write on rising edge, read data presented from the held address.
   logic [7:0] mem_a [2];
   logic [7:0] mem_b [2];
   always @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         mem_a[0] <= 8'h00; mem_a[1] <= 8'h00; mem_b[0] <= 8'h00; mem_b[1] <= 8'h00;
      end else begin
         if (a_en && a_rw) mem_a[a_addr] <= a_din;
         if (b_en && b_rw) mem_b[b_addr] <= b_din;
      end
   end
   assign a_rdout = mem_a[a_addr];
   assign b_rdout = mem_b[b_addr];

   // Current-instance view: sel=0 looks at A, sel=1 at B.
   logic       sel;
   logic       c_ack0, c_ack1, c_busy, c_en, c_rw;
   logic [0:0] c_addr;
   logic [7:0] c_dout, c_din;
   assign c_ack0 = sel ? b_ack0 : a_ack0;
   assign c_ack1 = sel ? b_ack1 : a_ack1;
   assign c_busy = sel ? b_busy : a_busy;
   assign c_en   = sel ? b_en   : a_en;
   assign c_rw   = sel ? b_rw   : a_rw;
   assign c_addr = sel ? b_addr : a_addr;
   assign c_dout = sel ? b_dout : a_dout;
   assign c_din  = sel ? b_din  : a_din;

   typedef struct {
      logic       id;
      logic       rd;
      logic [7:0] data;
      int         lat;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc;
   logic [1:0] acks;
   logic [7:0] d;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input logic [1:0] r);
      if (sel) req_b = r;
      else     req_a = r;
   endtask

   // Waits up to maxc edges for an ACK on the current instance; cyc = -1 on timeout.
   task automatic wait_ack(input int maxc, output int c, output logic [1:0] a, output logic [7:0] dd);
      c = -1; a = 2'b00; dd = 8'h00;
      for (int i = 1; i <= maxc; i++) begin
         tick();
         if (c_ack0 || c_ack1) begin
            c = i; a = {c_ack1, c_ack0}; dd = c_dout;
            return;
         end
      end
   endtask

   task automatic test_reset();
      CLR = 1'b1; req_a = 2'b00; req_b = 2'b00;
      r_w0 = 1'b0; r_w1 = 1'b0; addr0 = 1'b0; addr1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
      tick(); tick();
      n_chk++;
      if ({a_ack0, a_ack1, a_busy, a_en, a_rw, a_addr, a_din, a_dout} !== 20'h0)
         $display("FAIL reset_a: got %h want 0", {a_ack0, a_ack1, a_busy, a_en, a_rw, a_addr, a_din, a_dout});
      else n_pass++;
      n_chk++;
      if ({b_ack0, b_ack1, b_busy, b_en, b_rw, b_addr, b_din, b_dout} !== 20'h0)
         $display("FAIL reset_b: got %h want 0", {b_ack0, b_ack1, b_busy, b_en, b_rw, b_addr, b_din, b_dout});
      else n_pass++;
      CLR = 1'b0;
   endtask

   task automatic test_idle_quiet();
      for (int i = 0; i < 10; i++) begin
         tick();
         n_chk++;
         if ({a_ack0, a_ack1, a_busy, a_en, b_ack0, b_ack1, b_busy, b_en} !== 8'h00)
            $display("FAIL idle_quiet cycle %0d: got %b want 00000000", i,
                     {a_ack0, a_ack1, a_busy, a_en, b_ack0, b_ack1, b_busy, b_en});
         else n_pass++;
      end
   endtask

   task automatic test_write();
      sel = 1'b0;
      r_w0 = 1'b1; addr0 = 1'b1; din0 = 8'hA5;
      set_req(2'b01);
      exp_q.push_back('{id: 1'b0, rd: 1'b0, data: 8'h00, lat: 2});
      tick();
      n_chk++;
      if ({c_en, c_rw, c_busy, c_addr, c_din} !== {1'b1, 1'b1, 1'b1, 1'b1, 8'hA5})
         $display("FAIL write_issue: got %b want 1111_10100101", {c_en, c_rw, c_busy, c_addr, c_din});
      else n_pass++;
      wait_ack(5, cyc, acks, d);
      e = exp_q.pop_front();
      n_chk++;
      if (cyc + 1 !== e.lat || acks !== {e.id, ~e.id})
         $display("FAIL write_ack: got lat %0d ack %b want lat %0d ack %b", cyc + 1, acks, e.lat, {e.id, ~e.id});
      else n_pass++;
      n_chk++;
      if ({c_busy, d} !== {1'b1, 8'h00})
         $display("FAIL write_hold: got busy %b dout %h want busy 1 dout 00", c_busy, d);
      else n_pass++;
      set_req(2'b00);
      tick();
      n_chk++;
      if ({c_ack0, c_ack1, c_busy, c_en, c_addr, c_din} !== 13'h0)
         $display("FAIL write_after: got %b want all 0", {c_ack0, c_ack1, c_busy, c_en, c_addr, c_din});
      else n_pass++;
   endtask

   task automatic test_read();
      // RD_LAT=1 read of the word written above
      sel = 1'b0;
      r_w1 = 1'b0; addr1 = 1'b1;
      set_req(2'b10);
      exp_q.push_back('{id: 1'b1, rd: 1'b1, data: 8'hA5, lat: 2});
      wait_ack(6, cyc, acks, d);
      e = exp_q.pop_front();
      n_chk++;
      if (cyc !== e.lat || acks !== {e.id, ~e.id} || d !== e.data)
         $display("FAIL read_lat1: got lat %0d ack %b dout %h want lat %0d ack %b dout %h",
                  cyc, acks, d, e.lat, {e.id, ~e.id}, e.data);
      else n_pass++;
      set_req(2'b00);
      tick();
      // RD_LAT=3: write A5 through requester 0, read back through requester 1
      sel = 1'b1;
      r_w0 = 1'b1; addr0 = 1'b1; din0 = 8'hA5;
      set_req(2'b01);
      exp_q.push_back('{id: 1'b0, rd: 1'b0, data: 8'h00, lat: 2});
      wait_ack(6, cyc, acks, d);
      e = exp_q.pop_front();
      n_chk++;
      if (cyc !== e.lat || acks !== {e.id, ~e.id})
         $display("FAIL write_b: got lat %0d ack %b want lat %0d ack %b", cyc, acks, e.lat, {e.id, ~e.id});
      else n_pass++;
      set_req(2'b00);
      tick();
      set_req(2'b10);
      exp_q.push_back('{id: 1'b1, rd: 1'b1, data: 8'hA5, lat: 4});
      wait_ack(8, cyc, acks, d);
      e = exp_q.pop_front();
      n_chk++;
      if (cyc !== e.lat || acks !== {e.id, ~e.id} || d !== e.data)
         $display("FAIL read_lat3: got lat %0d ack %b dout %h want lat %0d ack %b dout %h",
                  cyc, acks, d, e.lat, {e.id, ~e.id}, e.data);
      else n_pass++;
      set_req(2'b00);
      tick();
   endtask

   task automatic test_tie();
      logic [3:0] order;
      CLR = 1'b1; tick(); CLR = 1'b0;
      sel = 1'b0;
      r_w0 = 1'b1; r_w1 = 1'b1; addr0 = 1'b0; addr1 = 1'b1; din0 = 8'h11; din1 = 8'h22;
`ifdef ARB_ROUND_ROBIN_EN
      order = 4'b1010;
`else
      order = 4'b0000;
`endif
      for (int i = 0; i < 4; i++)
         exp_q.push_back('{id: order[i], rd: 1'b0, data: 8'h00, lat: (i == 0) ? 2 : 3});
      set_req(2'b11);
      for (int i = 0; i < 4; i++) begin
         wait_ack(8, cyc, acks, d);
         e = exp_q.pop_front();
         n_chk++;
         if (cyc !== e.lat || acks !== {e.id, ~e.id})
            $display("FAIL tie_%0d: got lat %0d ack %b want lat %0d ack %b", i, cyc, acks, e.lat, {e.id, ~e.id});
         else n_pass++;
      end
      set_req(2'b00);
      tick(); tick(); tick();
   endtask

   task automatic test_drop();
      sel = 1'b1;
      r_w0 = 1'b1; addr0 = 1'b0; din0 = 8'h3C;
      set_req(2'b01);
      exp_q.push_back('{id: 1'b0, rd: 1'b0, data: 8'h00, lat: 2});
      wait_ack(6, cyc, acks, d);
      e = exp_q.pop_front();
      n_chk++;
      if (cyc !== e.lat || acks !== {e.id, ~e.id})
         $display("FAIL drop_wr: got lat %0d ack %b want lat %0d ack %b", cyc, acks, e.lat, {e.id, ~e.id});
      else n_pass++;
      set_req(2'b00);
      tick();
      r_w0 = 1'b0;
      set_req(2'b01);
      exp_q.push_back('{id: 1'b0, rd: 1'b1, data: 8'h3C, lat: 4});
      tick(); tick();
      set_req(2'b00);
      wait_ack(6, cyc, acks, d);
      e = exp_q.pop_front();
      n_chk++;
      if (cyc + 2 !== e.lat || acks !== {e.id, ~e.id} || d !== e.data)
         $display("FAIL drop_rd: got lat %0d ack %b dout %h want lat %0d ack %b dout %h",
                  cyc + 2, acks, d, e.lat, {e.id, ~e.id}, e.data);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_chk++;
         if ({c_busy, c_ack0, c_ack1} !== 3'b000)
            $display("FAIL drop_idle %0d: got %b want 000", i, {c_busy, c_ack0, c_ack1});
         else n_pass++;
      end
   endtask

   task automatic test_clr_mid();
      sel = 1'b1;
      r_w1 = 1'b0; addr1 = 1'b1;
      set_req(2'b10);
      tick(); tick();
      n_chk++;
      if (c_busy !== 1'b1)
         $display("FAIL clr_pre: got busy %b want 1", c_busy);
      else n_pass++;
      #2 CLR = 1'b1;
      #1;
      n_chk++;
      if ({c_ack0, c_ack1, c_busy, c_en, c_rw, c_addr, c_din, c_dout} !== 20'h0)
         $display("FAIL clr_async: got %h want 0", {c_ack0, c_ack1, c_busy, c_en, c_rw, c_addr, c_din, c_dout});
      else n_pass++;
      set_req(2'b00);
      tick(); tick();
      CLR = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_chk++;
         if ({c_ack0, c_ack1, c_busy} !== 3'b000)
            $display("FAIL clr_noack %0d: got %b want 000", i, {c_ack0, c_ack1, c_busy});
         else n_pass++;
      end
      r_w1 = 1'b1; din1 = 8'h5A;
      set_req(2'b10);
      exp_q.push_back('{id: 1'b1, rd: 1'b0, data: 8'h00, lat: 2});
      wait_ack(6, cyc, acks, d);
      e = exp_q.pop_front();
      n_chk++;
      if (cyc !== e.lat || acks !== {e.id, ~e.id})
         $display("FAIL clr_wr: got lat %0d ack %b want lat %0d ack %b", cyc, acks, e.lat, {e.id, ~e.id});
      else n_pass++;
      set_req(2'b00);
      tick();
      r_w1 = 1'b0;
      set_req(2'b10);
      exp_q.push_back('{id: 1'b1, rd: 1'b1, data: 8'h5A, lat: 4});
      wait_ack(8, cyc, acks, d);
      e = exp_q.pop_front();
      n_chk++;
      if (cyc !== e.lat || acks !== {e.id, ~e.id} || d !== e.data)
         $display("FAIL clr_rd: got lat %0d ack %b dout %h want lat %0d ack %b dout %h",
                  cyc, acks, d, e.lat, {e.id, ~e.id}, e.data);
      else n_pass++;
      set_req(2'b00);
      tick();
   endtask

   initial begin
      sel = 1'b0;
      test_reset();
      test_idle_quiet();
      test_write();
      test_read();
      test_tie();
      test_drop();
      test_clr_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
